// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter onto a single-port RAM with 1-cycle read latency
// Ports: clk/reset (async, active high); m0_*/m1_* request (req, addr, we, wmask, wdata) and
// response (gnt, rvalid, rdata) ports; ram_* drives the RAM (en, byte we, word addr, wdata, rdata).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-3:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);
  logic prio_q, prio_d, rsp_valid_q, rsp_valid_d, rsp_owner_q, rsp_owner_d;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};
  always_comb begin
    m0_gnt = !reset && m0_req && (!m1_req || !prio_q);
    m1_gnt = !reset && m1_req && (!m0_req || prio_q);
    prio_d = m0_gnt ? 1'b1 : m1_gnt ? 1'b0 : prio_q;
    rsp_valid_d = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    rsp_owner_d = m1_gnt;
    ram_en = m0_gnt || m1_gnt;
    ram_addr = m1_gnt ? m1_addr[ADDR_WIDTH-1:2] : m0_addr[ADDR_WIDTH-1:2];
    ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
    ram_we = (m0_gnt && m0_we) ? m0_wmask : (m1_gnt && m1_we) ? m1_wmask : '0;
    m0_rvalid = !reset && rsp_valid_q && !rsp_owner_q;
    m1_rvalid = !reset && rsp_valid_q && rsp_owner_q;
    m0_rdata = ram_rdata;
    m1_rdata = ram_rdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and held-request random stimulus with a read-response scoreboard
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0] m0_wmask = '0, m1_wmask = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_we;
  logic [29:0] ram_addr;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit eprio = 1'b0;
  typedef struct {bit own; logic [31:0] data; int due;} rsp_t;
  rsp_t q[$];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][8*b+:8] <= ram_wdata[8*b+:8];
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      cmp("rvalid_owner", {62'd0, m1_rvalid, m0_rvalid}, q[0].own ? 64'd2 : 64'd1);
      cmp("rdata", q[0].own ? m1_rdata : m0_rdata, q[0].data);
      void'(q.pop_front());
    end else
      cmp("no_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
  end

  task automatic set0(input bit r, input bit we, input logic [31:0] a, input logic [3:0] mk, input logic [31:0] d);
    m0_req = r; m0_we = we; m0_addr = a; m0_wmask = mk; m0_wdata = d;
  endtask

  task automatic set1(input bit r, input bit we, input logic [31:0] a, input logic [3:0] mk, input logic [31:0] d);
    m1_req = r; m1_we = we; m1_addr = a; m1_wmask = mk; m1_wdata = d;
  endtask

  task automatic step(input bit e0, input bit e1);
    bit we;
    logic [31:0] a, d;
    logic [3:0] mk;
    @(negedge clk);
    cmp("m0_gnt", {63'd0, m0_gnt}, {63'd0, e0});
    cmp("m1_gnt", {63'd0, m1_gnt}, {63'd0, e1});
    cmp("ram_en", {63'd0, ram_en}, {63'd0, e0 | e1});
    if (e0 | e1) begin
      we = e1 ? m1_we : m0_we;
      a = e1 ? m1_addr : m0_addr;
      d = e1 ? m1_wdata : m0_wdata;
      mk = e1 ? m1_wmask : m0_wmask;
      cmp("ram_addr", {34'd0, ram_addr}, {34'd0, a[31:2]});
      cmp("ram_we", {60'd0, ram_we}, {60'd0, we ? mk : 4'h0});
      if (we) begin
        cmp("ram_wdata", {32'd0, ram_wdata}, {32'd0, d});
        for (int b = 0; b < 4; b++)
          if (mk[b]) shadow[a[9:2]][8*b+:8] = d[8*b+:8];
      end else
        q.push_back('{e1, shadow[a[9:2]], cyc + 1});
      eprio = e0;
    end else
      cmp("ram_we_idle", {60'd0, ram_we}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit p0, p1, e0, e1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA000_0000 + i;
      shadow[i] = 32'hA000_0000 + i;
    end
    set0(1, 1, 32'h100, 4'hF, 32'h1111_1111);
    set1(1, 0, 32'h200, 4'hF, 32'h0);
    #2;
    cmp("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
    cmp("rst_ram_en", {63'd0, ram_en}, 64'd0);
    cmp("rst_ram_we", {60'd0, ram_we}, 64'd0);
    set0(1, 0, 32'h100, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 0);
    step(0, 1);
    step(1, 0);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    set1(1, 1, 32'h0C, 4'b0011, 32'hDEAD_BEEF);
    step(0, 1);
    set1(0, 0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    set0(1, 0, 32'h0C, 4'hF, 32'h0);
    step(1, 0);
    set0(1, 0, 32'h0, 4'h0, 32'h0);
    repeat (4) step(1, 0);
    set0(1, 1, 32'h10, 4'h0, 32'h1234_5678);
    step(1, 0);
    set0(0, 0, 0, 0, 0);
    step(0, 0);
    set1(1, 0, 32'h10, 4'hF, 32'h0);
    step(0, 1);
    set1(0, 0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    set0(1, 0, 32'h20, 4'h0, 32'h0);
    step(1, 0);
    set0(1, 0, 32'h24, 4'h0, 32'h0);
    @(negedge clk);
    cmp("pre_rst_gnt", {63'd0, m0_gnt}, 64'd1);
    #2;
    reset = 1'b1;
    q.delete();
    eprio = 1'b0;
    set1(1, 0, 32'h28, 4'h0, 32'h0);
    #1;
    cmp("mid_rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
    cmp("mid_rst_ram_en", {63'd0, ram_en}, 64'd0);
    cmp("mid_rst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_hold_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
    reset = 1'b0;
    step(1, 0);
    step(0, 1);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!p0) begin
        p0 = $urandom_range(1, 0) == 1;
        set0(p0, $urandom_range(1, 0) == 1, 32'($urandom_range(63, 0)) << 2, 4'($urandom), $urandom);
      end
      if (!p1) begin
        p1 = $urandom_range(1, 0) == 1;
        set1(p1, $urandom_range(1, 0) == 1, 32'($urandom_range(63, 0)) << 2, 4'($urandom), $urandom);
      end
      e0 = p0 && (!p1 || !eprio);
      e1 = p1 && (!p0 || eprio);
      step(e0, e1);
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0);
    step(0, 0);
    cmp("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
